// File: rtl/id_decode_stage_if.sv
// IF/ID -> ID -> ID/EX bus for the vector decode stage.
// The slave modport is the decode stage; the master modport is the pipeline around it.
interface id_decode_stage_if #(
    parameter int DATA_W = 64
);
    logic [0:31]       IF_ID_Instr;
    logic              IF_ID_valid;
    logic              stall_in;
    logic              WB_wr_en;
    logic [0:4]        WB_rd;
    logic [0:DATA_W-1] WB_data;
    logic              EX_MEM_reg_write;
    logic [0:4]        EX_MEM_rd;

    logic              stall_out;
    logic              branch_taken;
    logic [0:15]       branch_target;
    logic [0:31]       ID_EX_Instr;
    logic [0:DATA_W-1] ID_EX_rA_data;
    logic [0:DATA_W-1] ID_EX_rB_data;
    logic [0:DATA_W-1] ID_EX_rD_data;
    logic              ID_EX_valid;
    logic              ID_EX_reg_write;
    logic              ID_EX_mem_read;
    logic              ID_EX_mem_write;

    modport master (
        output IF_ID_Instr, IF_ID_valid, stall_in, WB_wr_en, WB_rd, WB_data,
               EX_MEM_reg_write, EX_MEM_rd,
        input  stall_out, branch_taken, branch_target, ID_EX_Instr,
               ID_EX_rA_data, ID_EX_rB_data, ID_EX_rD_data, ID_EX_valid,
               ID_EX_reg_write, ID_EX_mem_read, ID_EX_mem_write
    );

    modport slave (
        input  IF_ID_Instr, IF_ID_valid, stall_in, WB_wr_en, WB_rd, WB_data,
               EX_MEM_reg_write, EX_MEM_rd,
        output stall_out, branch_taken, branch_target, ID_EX_Instr,
               ID_EX_rA_data, ID_EX_rB_data, ID_EX_rD_data, ID_EX_valid,
               ID_EX_reg_write, ID_EX_mem_read, ID_EX_mem_write
    );
endinterface

// File: rtl/id_decode_stage.sv
// Vector pipeline decode stage: register file, hazard detection, branch
// resolution and the ID/EX pipeline register. Bit 0 is the MSB everywhere.
module id_decode_stage #(
    parameter int          DATA_W    = 64,
    parameter int          NREGS     = 32,
    parameter logic [0:31] NOP_INSTR = 32'hF000_0000
) (
    input  logic clk,
    input  logic rst_n,
    id_decode_stage_if.slave bus
);
    localparam logic [0:5] OP_RALU  = 6'b101010;
    localparam logic [0:5] OP_LOAD  = 6'b100000;
    localparam logic [0:5] OP_STORE = 6'b100001;
    localparam logic [0:5] OP_BEZ   = 6'b100010;
    localparam logic [0:5] OP_BNEZ  = 6'b100011;

    typedef struct packed {
        logic [0:31]       instr;
        logic [0:DATA_W-1] ra;
        logic [0:DATA_W-1] rb;
        logic [0:DATA_W-1] rd;
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } id_ex_t;

    localparam id_ex_t BUBBLE = {NOP_INSTR, {(3*DATA_W+4){1'b0}}};

    logic [0:DATA_W-1] rf [NREGS];
    id_ex_t            ex;

    logic [0:31] ins;
    logic [0:5]  op, func;
    logic [0:4]  rd, ra, rb, ex_rd;
    assign ins   = bus.IF_ID_Instr;
    assign op    = ins[0:5];
    assign rd    = ins[6:10];
    assign ra    = ins[11:15];
    assign rb    = ins[16:20];
    assign func  = ins[26:31];
    assign ex_rd = ex.instr[6:10];

    logic is_ralu, is_load, is_store, is_bez, is_bnez, is_br;
    assign is_ralu  = (op == OP_RALU);
    assign is_load  = (op == OP_LOAD);
    assign is_store = (op == OP_STORE);
    assign is_bez   = (op == OP_BEZ);
    assign is_bnez  = (op == OP_BNEZ);
    assign is_br    = is_bez | is_bnez;

    logic dec_rw, use_a, use_b, use_d;
    assign dec_rw = ((is_ralu && func != '0) || is_load) && rd != '0;
    assign use_a  = is_ralu | is_load | is_store;
    assign use_b  = is_ralu;
    assign use_d  = is_store | is_br;

    // Combinational read with same-cycle writeback forwarding; R0 is hardwired zero.
    function automatic logic [0:DATA_W-1] rd_port(
        input logic [0:4] idx, input logic [0:DATA_W-1] stored,
        input logic wb_en, input logic [0:4] wb_rd, input logic [0:DATA_W-1] wb_data);
        if (idx == '0) return '0;
        if (wb_en && wb_rd == idx) return wb_data;
        return stored;
    endfunction

    logic [0:DATA_W-1] ra_val, rb_val, rd_val;
    assign ra_val = rd_port(ra, rf[ra], bus.WB_wr_en, bus.WB_rd, bus.WB_data);
    assign rb_val = rd_port(rb, rf[rb], bus.WB_wr_en, bus.WB_rd, bus.WB_data);
    assign rd_val = rd_port(rd, rf[rd], bus.WB_wr_en, bus.WB_rd, bus.WB_data);

    function automatic logic src_hit(input logic [0:4] src, input logic used, input logic [0:4] tgt);
        return used && src != '0 && src == tgt;
    endfunction

    logic load_use, br_haz, bubble;
    assign load_use = bus.IF_ID_valid && ex.valid && ex.mem_read &&
                      (src_hit(ra, use_a, ex_rd) || src_hit(rb, use_b, ex_rd) ||
                       src_hit(rd, use_d, ex_rd));
    // A branch waits until any in-flight producer of its condition register has written back.
    assign br_haz   = bus.IF_ID_valid && is_br && rd != '0 &&
                      ((ex.reg_write && ex_rd == rd) ||
                       (bus.EX_MEM_reg_write && bus.EX_MEM_rd == rd));
    assign bubble   = load_use || br_haz || is_br || !bus.IF_ID_valid;

    assign bus.stall_out     = bus.stall_in || load_use || br_haz;
    assign bus.branch_target = ins[16:31];
    assign bus.branch_taken  = bus.IF_ID_valid && is_br && !bus.stall_out &&
                               (is_bez ? (rd_val == '0) : (rd_val != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (bus.WB_wr_en && bus.WB_rd != '0) begin
            rf[bus.WB_rd] <= bus.WB_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex <= BUBBLE;
        end else if (!bus.stall_in) begin
            if (bubble) begin
                ex <= BUBBLE;
            end else begin
                ex.instr     <= ins;
                ex.ra        <= ra_val;
                ex.rb        <= rb_val;
                ex.rd        <= rd_val;
                ex.valid     <= 1'b1;
                ex.reg_write <= dec_rw;
                ex.mem_read  <= is_load;
                ex.mem_write <= is_store;
            end
        end
    end

    assign bus.ID_EX_Instr     = ex.instr;
    assign bus.ID_EX_rA_data   = ex.ra;
    assign bus.ID_EX_rB_data   = ex.rb;
    assign bus.ID_EX_rD_data   = ex.rd;
    assign bus.ID_EX_valid     = ex.valid;
    assign bus.ID_EX_reg_write = ex.reg_write;
    assign bus.ID_EX_mem_read  = ex.mem_read;
    assign bus.ID_EX_mem_write = ex.mem_write;
endmodule

// File: tb/tb_id_decode_stage.sv
// Directed table-driven bench for id_decode_stage plus hand sequences for
// downstream stall and asynchronous reset.
module tb_id_decode_stage;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_decode_stage_if #(.DATA_W(64)) bus ();
    id_decode_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    localparam logic [0:31] NOP = 32'hF000_0000;
    localparam logic [0:5]  RALU = 6'b101010, LOAD = 6'b100000, STORE = 6'b100001,
                            BEZ = 6'b100010, BNEZ = 6'b100011;
    localparam logic [0:63] C = 64'h0123_4567_89AB_CDEF;
    localparam logic [0:63] F = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [0:63] Z = 64'h0;
    localparam logic [0:63] D = 64'hDEAD_BEEF_0000_1111;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [0:31] instr;  logic valid;
        logic wb_en; logic [0:4] wb_rd; logic [0:63] wb_data;
        logic exm_rw; logic [0:4] exm_rd;
        logic e_stall; logic e_taken; logic [0:15] e_tgt;
        logic [0:31] e_instr; logic e_valid, e_rw, e_mr, e_mw;
        logic [0:63] e_ra, e_rb, e_rd;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [0:31] ralu(input logic [0:4] rd, ra, rb, input logic [0:5] fn);
        return {RALU, rd, ra, rb, 5'b0, fn};
    endfunction
    function automatic logic [0:31] mem(input logic [0:5] op, input logic [0:4] rd, ra, input logic [0:15] imm);
        return {op, rd, ra, imm};
    endfunction
    function automatic logic [0:31] br(input logic [0:5] op, input logic [0:4] rd, input logic [0:15] imm);
        return {op, rd, 5'b0, imm};
    endfunction

    task automatic add(input logic [0:31] instr, input logic valid,
                       input logic wb_en, input logic [0:4] wb_rd, input logic [0:63] wb_data,
                       input logic exm_rw, input logic [0:4] exm_rd,
                       input logic e_stall, input logic e_taken, input logic [0:15] e_tgt,
                       input logic [0:31] e_instr, input logic e_valid, e_rw, e_mr, e_mw,
                       input logic [0:63] e_ra, e_rb, e_rd);
        vec_t v;
        v.instr = instr; v.valid = valid; v.wb_en = wb_en; v.wb_rd = wb_rd; v.wb_data = wb_data;
        v.exm_rw = exm_rw; v.exm_rd = exm_rd; v.e_stall = e_stall; v.e_taken = e_taken;
        v.e_tgt = e_tgt; v.e_instr = e_instr; v.e_valid = e_valid; v.e_rw = e_rw;
        v.e_mr = e_mr; v.e_mw = e_mw; v.e_ra = e_ra; v.e_rb = e_rb; v.e_rd = e_rd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [0:31] instr, input logic valid, input logic stall,
                         input logic wb_en, input logic [0:4] wb_rd, input logic [0:63] wb_data,
                         input logic exm_rw, input logic [0:4] exm_rd);
        bus.IF_ID_Instr = instr; bus.IF_ID_valid = valid; bus.stall_in = stall;
        bus.WB_wr_en = wb_en; bus.WB_rd = wb_rd; bus.WB_data = wb_data;
        bus.EX_MEM_reg_write = exm_rw; bus.EX_MEM_rd = exm_rd;
    endtask

    task automatic chk_idex(input string nm, input logic [0:31] instr, input logic valid, rw, mr, mw,
                            input logic [0:63] ra, rb, rd);
        chk({nm, ".instr"}, {32'h0, bus.ID_EX_Instr}, {32'h0, instr});
        chk({nm, ".valid"}, {63'h0, bus.ID_EX_valid}, {63'h0, valid});
        chk({nm, ".reg_write"}, {63'h0, bus.ID_EX_reg_write}, {63'h0, rw});
        chk({nm, ".mem_read"}, {63'h0, bus.ID_EX_mem_read}, {63'h0, mr});
        chk({nm, ".mem_write"}, {63'h0, bus.ID_EX_mem_write}, {63'h0, mw});
        chk({nm, ".rA"}, bus.ID_EX_rA_data, ra);
        chk({nm, ".rB"}, bus.ID_EX_rB_data, rb);
        chk({nm, ".rD"}, bus.ID_EX_rD_data, rd);
    endtask

    logic [0:31] i_st;

    initial begin
        rst_n = 1'b0;
        drive(NOP, 1'b0, 1'b0, 1'b0, 5'd0, Z, 1'b0, 5'd0);
        #12;
        chk_idex("reset", NOP, 0, 0, 0, 0, Z, Z, Z);
        @(negedge clk); rst_n = 1'b1;

        //  instr                          vld wb  rd     data exw exrd  stl tkn tgt        e_instr                        ev rw mr mw  ra rb rd
        add(NOP,                           0,  1,  5'd3,  C,   0,  5'd0, 0,  0,  16'h0,     NOP,                           0, 0, 0, 0, Z, Z, Z);
        add(ralu(5'd5, 5'd3, 5'd0, 6'd1),  1,  0,  5'd0,  Z,   0,  5'd0, 0,  0,  16'h0,     ralu(5'd5, 5'd3, 5'd0, 6'd1),  1, 1, 0, 0, C, Z, Z);
        add(ralu(5'd6, 5'd7, 5'd3, 6'd1),  1,  1,  5'd7,  F,   0,  5'd0, 0,  0,  16'h0,     ralu(5'd6, 5'd7, 5'd3, 6'd1),  1, 1, 0, 0, F, C, Z);
        add(ralu(5'd8, 5'd0, 5'd0, 6'd1),  1,  1,  5'd0,  64'h5555_5555_5555_5555, 0, 5'd0, 0, 0, 16'h0,
                                                                                        ralu(5'd8, 5'd0, 5'd0, 6'd1),  1, 1, 0, 0, Z, Z, Z);
        add(ralu(5'd9, 5'd0, 5'd7, 6'd3),  1,  0,  5'd0,  Z,   0,  5'd0, 0,  0,  16'h0,     ralu(5'd9, 5'd0, 5'd7, 6'd3),  1, 1, 0, 0, Z, F, Z);
        add(mem(LOAD, 5'd4, 5'd3, 16'h0),  1,  0,  5'd0,  Z,   0,  5'd0, 0,  0,  16'h0,     mem(LOAD, 5'd4, 5'd3, 16'h0),  1, 1, 1, 0, C, Z, Z);
        add(ralu(5'd10, 5'd4, 5'd3, 6'd2), 1,  0,  5'd0,  Z,   0,  5'd0, 1,  0,  16'h0,     NOP,                           0, 0, 0, 0, Z, Z, Z);
        add(ralu(5'd10, 5'd4, 5'd3, 6'd2), 1,  0,  5'd0,  Z,   0,  5'd0, 0,  0,  16'h0,     ralu(5'd10, 5'd4, 5'd3, 6'd2), 1, 1, 0, 0, Z, C, Z);
        add(mem(LOAD, 5'd0, 5'd3, 16'h0),  1,  0,  5'd0,  Z,   0,  5'd0, 0,  0,  16'h0,     mem(LOAD, 5'd0, 5'd3, 16'h0),  1, 0, 1, 0, C, Z, Z);
        add(ralu(5'd11, 5'd0, 5'd3, 6'd2), 1,  0,  5'd0,  Z,   0,  5'd0, 0,  0,  16'h0,     ralu(5'd11, 5'd0, 5'd3, 6'd2), 1, 1, 0, 0, Z, C, Z);
        add(br(BEZ, 5'd2, 16'h1234),       1,  0,  5'd0,  Z,   0,  5'd0, 0,  1,  16'h1234,  NOP,                           0, 0, 0, 0, Z, Z, Z);
        add(br(BNEZ, 5'd2, 16'hABCD),      1,  0,  5'd0,  Z,   0,  5'd0, 0,  0,  16'h0,     NOP,                           0, 0, 0, 0, Z, Z, Z);
        add(br(BEZ, 5'd2, 16'h1234),       1,  0,  5'd0,  Z,   1,  5'd2, 1,  0,  16'h0,     NOP,                           0, 0, 0, 0, Z, Z, Z);
        add(ralu(5'd2, 5'd3, 5'd0, 6'd1),  1,  0,  5'd0,  Z,   0,  5'd0, 0,  0,  16'h0,     ralu(5'd2, 5'd3, 5'd0, 6'd1),  1, 1, 0, 0, C, Z, Z);
        add(br(BNEZ, 5'd2, 16'hABCD),      1,  0,  5'd0,  Z,   0,  5'd0, 1,  0,  16'h0,     NOP,                           0, 0, 0, 0, Z, Z, Z);
        add(br(BNEZ, 5'd2, 16'hABCD),      1,  1,  5'd2,  64'd5, 0, 5'd0, 0, 1,  16'hABCD,  NOP,                           0, 0, 0, 0, Z, Z, Z);
        add(mem(STORE, 5'd7, 5'd3, 16'h0), 1,  0,  5'd0,  Z,   0,  5'd0, 0,  0,  16'h0,     mem(STORE, 5'd7, 5'd3, 16'h0), 1, 0, 0, 1, C, Z, F);

        foreach (vecs[k]) begin
            string nm;
            nm = $sformatf("v%0d", k);
            @(negedge clk);
            drive(vecs[k].instr, vecs[k].valid, 1'b0, vecs[k].wb_en, vecs[k].wb_rd, vecs[k].wb_data,
                  vecs[k].exm_rw, vecs[k].exm_rd);
            #1;
            chk({nm, ".stall_out"}, {63'h0, bus.stall_out}, {63'h0, vecs[k].e_stall});
            chk({nm, ".branch_taken"}, {63'h0, bus.branch_taken}, {63'h0, vecs[k].e_taken});
            if (vecs[k].e_taken) chk({nm, ".target"}, {48'h0, bus.branch_target}, {48'h0, vecs[k].e_tgt});
            @(posedge clk); #1;
            chk_idex(nm, vecs[k].e_instr, vecs[k].e_valid, vecs[k].e_rw, vecs[k].e_mr, vecs[k].e_mw,
                     vecs[k].e_ra, vecs[k].e_rb, vecs[k].e_rd);
        end

        // Downstream stall: ID/EX holds the store, branches are suppressed, WB still lands.
        i_st = mem(STORE, 5'd7, 5'd3, 16'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(br(BEZ, 5'd0, 16'h0F0F), 1'b1, 1'b1, 1'b1, 5'd20, D, 1'b0, 5'd0);
            #1;
            chk($sformatf("stall%0d.stall_out", c), {63'h0, bus.stall_out}, 64'd1);
            chk($sformatf("stall%0d.branch_taken", c), {63'h0, bus.branch_taken}, 64'd0);
            @(posedge clk); #1;
            chk_idex($sformatf("stall%0d", c), i_st, 1, 0, 0, 1, C, Z, F);
        end
        @(negedge clk);
        drive(ralu(5'd12, 5'd20, 5'd2, 6'd1), 1'b1, 1'b0, 1'b0, 5'd0, Z, 1'b0, 5'd0);
        #1;
        chk("post_stall.stall_out", {63'h0, bus.stall_out}, 64'd0);
        @(posedge clk); #1;
        chk_idex("post_stall", ralu(5'd12, 5'd20, 5'd2, 6'd1), 1, 1, 0, 0, D, 64'd5, Z);

        // Asynchronous reset mid-cycle clears ID/EX with no edge, and the register file.
        #3; rst_n = 1'b0;
        #1;
        chk_idex("async_rst", NOP, 0, 0, 0, 0, Z, Z, Z);
        @(negedge clk); rst_n = 1'b1;
        drive(ralu(5'd13, 5'd3, 5'd20, 6'd1), 1'b1, 1'b0, 1'b0, 5'd0, Z, 1'b0, 5'd0);
        @(posedge clk); #1;
        chk_idex("after_rst_a", ralu(5'd13, 5'd3, 5'd20, 6'd1), 1, 1, 0, 0, Z, Z, Z);
        @(negedge clk);
        drive(ralu(5'd14, 5'd7, 5'd2, 6'd1), 1'b1, 1'b0, 1'b0, 5'd0, Z, 1'b0, 5'd0);
        @(posedge clk); #1;
        chk_idex("after_rst_b", ralu(5'd14, 5'd7, 5'd2, 6'd1), 1, 1, 0, 0, Z, Z, Z);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
- Instruction-decode stage of the 5-stage vector pipeline, directly upstream of the vector ALU.
- Owns the 32 x 64-bit vector register file, decodes the IF/ID instruction and reads operands.
- Detects load-use and branch hazards, resolves BEZ/BNEZ, and drives the ID/EX pipeline register the ALU consumes (instruction word plus operand values).
- Bit numbering is big-endian throughout: bit 0 is the MSB.

Parameters:
- DATA_W, 64, register/operand width
- NREGS, 32, register count; R0 reads as zero, writes to R0 are ignored
- NOP_INSTR, 32'hF000_0000, bubble encoding: opcode 111100, all other bits 0

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- IF_ID_Instr  in  [0:31]  fetched instruction
- IF_ID_valid  in  1  IF_ID_Instr is a real instruction
- stall_in  in  1  downstream (MEM) stall; freeze ID/EX
- WB_wr_en  in  1  writeback enable
- WB_rd  in  [0:4]  writeback destination
- WB_data  in  [0:63]  writeback data
- EX_MEM_reg_write  in  1  EX/MEM instruction will write a register
- EX_MEM_rd  in  [0:4]  its destination
- stall_out  out  1  hold PC and IF/ID this cycle
- branch_taken  out  1  redirect fetch (combinational)
- branch_target  out  [0:15]  IF_ID_Instr[16:31] (combinational)
- ID_EX_Instr  out  [0:31]  instruction to the ALU
- ID_EX_rA_data  out  [0:63]  value of register rA
- ID_EX_rB_data  out  [0:63]  value of register rB
- ID_EX_rD_data  out  [0:63]  value of register rD (store data)
- ID_EX_valid  out  1  ID/EX holds a real instruction
- ID_EX_reg_write  out  1  instruction writes rD
- ID_EX_mem_read  out  1  LOAD
- ID_EX_mem_write  out  1  STORE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n).
- Reset values: ID_EX_Instr = NOP_INSTR; all other ID/EX outputs 0; all registers 0.
- Field decode: opcode [0:5], rD [6:10], rA [11:15], rB [16:20], WW [24:25], func [26:31], immediate [16:31].
- Opcodes: R_ALU 101010; LOAD 100000; STORE 100001; BEZ 100010; BNEZ 100011; NOP 111100. Any other opcode is treated as NOP.
- Control signals:
  - reg_write = R_ALU with func != 000000, or LOAD; forced to 0 when rD = 0.
  - mem_read = LOAD.
  - mem_write = STORE.
- Source registers used for hazard checks:
  - R_ALU: rA and rB, always, including unary functions (conservative).
  - LOAD: rA.
  - STORE: rA and rD.
  - BEZ/BNEZ: rD.
  - NOP: none.
  - R0 never causes a hazard.
- Register file:
  - Write: synchronous on the rising edge when WB_wr_en = 1 and WB_rd != 0.
  - Read: combinational.
  - Write-through: if WB_wr_en = 1 and WB_rd equals a nonzero read index in the same cycle, the read returns WB_data.
- Load-use hazard:
  - Condition: IF_ID_valid, ID_EX_valid, ID_EX_mem_read, and ID_EX rD matches a source register.
  - Response: stall_out = 1; a bubble enters ID/EX next edge.
- Branch hazard:
  - Condition: a valid BEZ/BNEZ whose rD matches either the ID_EX destination (ID_EX_reg_write) or EX_MEM_rd (EX_MEM_reg_write).
  - Response: stall_out = 1; bubble inserted.
  - Rule: a branch never resolves on stale data.
- Branch resolution (valid branch, no hazard):
  - BEZ taken when register rD == 0; BNEZ taken when register rD != 0.
  - branch_taken is asserted in the same cycle; branch_target = immediate.
  - The branch enters ID/EX as a bubble.
  - branch_taken = 0 whenever stall_out = 1 or stall_in = 1.
- Bubble contents: ID_EX_Instr = NOP_INSTR; valid, reg_write, mem_read, mem_write = 0; data outputs 0.
- ID/EX update priority per edge:
  - rst_n low: reset values.
  - stall_in = 1: hold all ID/EX outputs.
  - hazard, branch, or IF_ID_valid = 0: bubble.
  - otherwise: capture the decoded instruction and operands.
- stall_out = stall_in OR load-use hazard OR branch hazard.
- Register-file writes proceed regardless of any stall.
- Latency: one cycle from IF_ID_Instr to the ID_EX outputs.
- Reset mid-operation: in-flight ID/EX contents are discarded; no register write occurs while rst_n is low.

Test Plan:
- Reset, then write R3 = 0x0123_4567_89AB_CDEF via WB; then R_ALU VADD rD=5, rA=3, rB=0 → next cycle ID_EX_rA_data = 0x0123456789ABCDEF, ID_EX_rB_data = 0, reg_write = 1, valid = 1.
- Same-cycle WB of R7 = 0xFF..FF while decoding rA=7 → ID_EX_rA_data = 0xFFFF_FFFF_FFFF_FFFF (write-through); WB to R0 with 0x55.. → R0 still reads 0.
- LOAD rD=4 followed by VAND rA=4 → stall_out = 1 for exactly one cycle; ID/EX shows NOP_INSTR with valid = 0; VAND issues the next cycle. A LOAD rD=0 followed by a user of R0 → no stall.
- BEZ rD=2 with R2 = 0, no hazard → branch_taken = 1, branch_target = IF_ID_Instr[16:31]. BNEZ under the same conditions → branch_taken = 0. BEZ with EX_MEM_rd = 2 and EX_MEM_reg_write = 1 → stall_out = 1, branch_taken = 0.
- stall_in held for 3 cycles with a valid instruction in ID/EX → ID/EX outputs unchanged and stall_out = 1 throughout; a WB write during the stall still lands.
- Assert rst_n low mid-stream → ID/EX outputs immediately show NOP_INSTR and zeros, with no clock edge needed; all registers read 0 after reset.
